prog_clock_divider: RTL
=======================

Name: prog_clock_divider

Overview:
- Programmable successor to the fixed power-of-two divider chain that sits after the on-chip ring oscillator.
- Divides `clk` (the oscillator output) by any integer N in 2..2^WIDTH with near-50% duty.
- Divisor changes are glitch-free, applied only at a period boundary, with a load/ack handshake.
- Enable start/stop is graceful. A power-of-two tap bus is kept for the existing debug outputs.

Parameters:
- WIDTH, 8: divisor register width; max divisor 2^WIDTH.
- TAPS, 7: number of power-of-two tap outputs (divide by 2..2^TAPS).
- RESET_DIV, 128: active divisor after reset; must be 2..2^WIDTH.

Ports:
- clk  input  1  clock to divide (ring oscillator output).
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  1  run request for the programmable divider and tap chain.
- div_val  input  WIDTH  requested divisor; 0 encodes 2^WIDTH; 1 is clamped to 2.
- div_load  input  1  one-cycle strobe that captures div_val.
- div_ack  output  1  one-cycle pulse when a pending divisor becomes active.
- busy  output  1  a captured divisor is pending.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse coincident with each clk_out rising edge.
- taps  output  TAPS  taps[i] = clk divided by 2^(i+1).

Behaviour:
- Reset values (async on rst_n low, all outputs):
  - clk_out=0, tick=0, div_ack=0, busy=0, taps=0.
  - Internal: cnt=0, running=0, active N=RESET_DIV.
- Divisor decode: eff = (div_val==0) ? 2^WIDTH : (div_val==1) ? 2 : div_val. Decoded at capture.
- Running step, every edge with running=1:
  - clk_out <= (cnt < floor(N/2)); tick <= (cnt==0).
  - cnt <= (cnt==N-1) ? 0 : cnt+1.
  - Result: clk_out is high floor(N/2) cycles and low ceil(N/2) cycles. Example: N=5 gives 2 high, 3 low.
- Start: running=0 and en=1 at an edge → running<=1 and the running step executes with cnt=0. clk_out=1 and tick=1 after that first edge.
- Graceful stop:
  - en=0 while running: the divider continues until the edge where cnt==N-1.
  - At that edge: cnt<=0, clk_out<=0, running<=0.
  - A truncated high pulse never occurs.
  - en re-asserted before that edge: counting simply continues.
- Divisor handshake:
  - div_load=1 at an edge → pending<=eff, busy<=1.
  - Apply edge = edge where (cnt==N-1 and running) or (running==0). On that edge: N<=pending, busy<=0, div_ack<=1 for one cycle.
  - The new N governs the next period, starting at cnt=0.
- Simultaneous load and apply edge:
  - The old pending value is applied and acked.
  - The new value becomes pending; busy stays 1.
- Repeated loads while busy: pending is overwritten. Only the last value is applied, with one ack.
- Taps: a TAPS-bit counter increments on every edge with en=1 and holds when en=0. It is not graceful.
- Reset mid-operation: immediate return to reset values. Any pending divisor is discarded.
- div_val is sampled only on div_load edges.

Optional Feature:
- Macro: CLK_DIV_PERIOD_CNT_EN.
- With the macro defined, two ports are added:
  - period_clr input 1.
  - period_cnt output 16: count of tick pulses, saturating at 16'hFFFF, reset 0.
  - period_clr=1 clears the count to 0 on that edge; clear wins over a simultaneous tick.
- Without the macro: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package clk_div_pkg:
  - localparams DEF_WIDTH=8 and DEF_TAPS=7.
  - function decode_div(val, width) implementing the 0/1 encoding rule.
  - typedef for the period counter width (16).
- Sub-module clk_div_tap_chain(clk, rst_n, en, taps): the TAPS-bit enable-gated counter.
- Everything else lives in prog_clock_divider.

Test Plan:
- Reset, then en=1 with RESET_DIV=128 → clk_out rises at edge 1, high 64 / low 64; tick every 128 cycles; taps[0] toggles every edge.
- div_load div_val=5 mid-period → busy=1; div_ack exactly at the cnt==127 edge; then periods are 5 cycles: 2 high, 3 low.
- div_val=0 (WIDTH=8) → period 256: 128/128. div_val=1 → period 2: 1/1.
- Two loads (9 then 12) before the boundary → one ack; period 12: 6/6. Load coincident with the apply edge → two acks over successive boundaries.
- en dropped during the high phase with N=10 → clk_out finishes 5 high and 5 low, then holds 0. Re-enable → clk_out=1 on the next edge.
- rst_n low mid-period → all outputs 0 asynchronously; after release N=128. With CLK_DIV_PERIOD_CNT_EN: period_cnt counts ticks, and period_clr coincident with a tick gives 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
// Holds the default widths, the divisor decode rule and the
// period counter type used when CLK_DIV_PERIOD_CNT_EN is defined.
package clk_div_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_TAPS     = 7;
  localparam int PERIOD_CNT_W = 16;

  typedef logic [PERIOD_CNT_W-1:0] period_cnt_t;

  localparam period_cnt_t PERIOD_CNT_MAX = '1;

  // A requested value of 0 stands for the largest divisor 2^width and a
  // value of 1 cannot produce a 50% clock, so it is promoted to 2.
  function automatic int unsigned decode_div(input int unsigned val,
                                             input int unsigned width);
    if (val == 0) begin
      return 32'd1 << width;
    end else if (val == 1) begin
      return 32'd2;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/clk_div_tap_chain.sv
// Power-of-two tap chain kept for the legacy debug outputs.
// taps[i] is clk divided by 2^(i+1); the chain stops dead when en is low
// (no graceful completion, unlike the programmable divider).
module clk_div_tap_chain
  import clk_div_pkg::*;
#(
  parameter int TAPS = DEF_TAPS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic [TAPS-1:0] taps
);

  // Free-running binary counter; each bit is one tap output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else if (en) begin
      taps <= taps + TAPS'(1);
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// Programmable integer clock divider for the ring oscillator output.
// Divides clk by N in 2..2^WIDTH with clk_out high floor(N/2) cycles and
// low ceil(N/2) cycles. New divisors are captured with div_load and only
// take effect at a period boundary (div_ack marks the switch). Dropping en
// lets the current period finish before clk_out parks low.
// Optional feature: define CLK_DIV_PERIOD_CNT_EN to add period_clr and a
// saturating 16-bit period_cnt that counts tick pulses.
module prog_clock_divider
  import clk_div_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int TAPS      = DEF_TAPS,
  parameter int RESET_DIV = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             busy,
  output logic             clk_out,
  output logic             tick,
  output logic [TAPS-1:0]  taps
`ifdef CLK_DIV_PERIOD_CNT_EN
  ,
  input  logic             period_clr,
  output period_cnt_t      period_cnt
`endif
);

  // One extra bit so the divisor 2^WIDTH is representable.
  localparam int NW = WIDTH + 1;
  typedef logic [NW-1:0] div_t;

  logic [WIDTH-1:0] cnt;
  logic             running;
  div_t             n_act;
  div_t             pending;
  div_t             decoded;
  div_t             half;
  logic             last_slot;
  logic             apply_edge;
  logic             stepping;
  logic             tick_next;

  assign decoded    = div_t'(decode_div(32'(div_val), WIDTH));
  assign half       = n_act >> 1;
  assign last_slot  = running && ({1'b0, cnt} == (n_act - div_t'(1)));
  assign apply_edge = last_slot || !running;
  assign stepping   = running || en;
  assign tick_next  = stepping && (cnt == '0);

  // Period counter and clk_out/tick generation, including graceful stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      running <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (stepping) begin
        clk_out <= ({1'b0, cnt} < half);
        tick    <= (cnt == '0);
        if (en) begin
          running <= 1'b1;
        end
        if (last_slot) begin
          cnt <= '0;
          if (!en) begin
            running <= 1'b0;
            clk_out <= 1'b0;
          end
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end
  end

  // Divisor load/apply handshake; a pending value switches in only at a
  // period boundary or while idle, and a load on that same edge queues up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_act   <= div_t'(RESET_DIV);
      pending <= '0;
      busy    <= 1'b0;
      div_ack <= 1'b0;
    end else begin
      div_ack <= 1'b0;
      if (apply_edge && busy) begin
        n_act   <= pending;
        busy    <= 1'b0;
        div_ack <= 1'b1;
      end
      if (div_load) begin
        pending <= decoded;
        busy    <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_PERIOD_CNT_EN
  // Saturating count of periods; an explicit clear beats a same-edge tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (period_clr) begin
      period_cnt <= '0;
    end else if (tick_next && (period_cnt != PERIOD_CNT_MAX)) begin
      period_cnt <= period_cnt + PERIOD_CNT_W'(1);
    end
  end
`else
  logic unused_tick_next;
  assign unused_tick_next = tick_next;
`endif

  clk_div_tap_chain #(
    .TAPS(TAPS)
  ) u_tap_chain (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .taps (taps)
  );

endmodule
